// File: rtl/dmem_pkg.sv
// Shared constants and types for the block-granular data-memory responder.
package dmem_pkg;

  localparam int DMEM_ADDR_WIDTH = 28;
  localparam int DMEM_DATA_WIDTH = 128;
  localparam int DMEM_WORD_WIDTH = 32;

  localparam logic [1:0] DMEM_IDLE   = 2'b00;
  localparam logic [1:0] DMEM_ACCESS = 2'b01;
  localparam logic [1:0] DMEM_RESP   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = DMEM_IDLE,
    ST_ACCESS = DMEM_ACCESS,
    ST_RESP   = DMEM_RESP
  } dmem_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } dmem_op_e;

endpackage

// File: rtl/dmem_line_array.sv
// Single-port line storage: synchronous write, registered read output that
// only changes on a read enable and clears on reset (contents are not cleared).
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[index] <= wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[index];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_block_responder.sv
// Fixed-latency cache-line responder below the data cache.
// Optional access counters are built when DMEM_ACCESS_STATS_EN is defined.
module dmem_block_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH    = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DMEM_DATA_WIDTH,
  parameter int DEPTH_LOG2    = 8,
  parameter int READ_LATENCY  = 20,
  parameter int WRITE_LATENCY = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  busywait
`ifdef DMEM_ACCESS_STATS_EN
  ,
  output logic [31:0]           read_count,
  output logic [31:0]           write_count
`endif
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  dmem_state_e           state_q;
  dmem_op_e              op_q;
  logic [DEPTH_LOG2-1:0] index_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]      cnt_q;

  logic request;
  logic fire;
  logic mem_we;
  logic mem_re;

  // Upper address bits alias onto the same line and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[ADDR_WIDTH-1:DEPTH_LOG2];

  assign request = read | write;
  assign fire    = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign mem_we  = fire && (op_q == OP_WRITE);
  assign mem_re  = fire && (op_q == OP_READ);

  // Combinational so the requester sees busy in the very cycle it asks.
  assign busywait = ((state_q == ST_IDLE) && request) || (state_q == ST_ACCESS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      index_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (request) begin
            // A simultaneous read and write is served as a write.
            op_q    <= write ? OP_WRITE : OP_READ;
            index_q <= address[DEPTH_LOG2-1:0];
            wdata_q <= writedata;
            cnt_q   <= write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dmem_line_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_lines (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .index (index_q),
    .wdata (wdata_q),
    .rdata (readdata)
  );

`ifdef DMEM_ACCESS_STATS_EN
  logic [31:0] read_count_q;
  logic [31:0] write_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      if (mem_re) read_count_q  <= read_count_q + 32'd1;
      if (mem_we) write_count_q <= write_count_q + 32'd1;
    end
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_dmem_block_responder.sv
// Scoreboard bench for dmem_block_responder: a driver pushes expected responses,
// a monitor pops and compares whenever a response cycle appears.
module tb_dmem_block_responder;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int RL = 5;
  localparam int WL = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          read;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          busywait;
`ifdef DMEM_ACCESS_STATS_EN
  logic [31:0]   read_count;
  logic [31:0]   write_count;
`endif

  always #5 clock = ~clock;

  dmem_block_responder #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .DEPTH_LOG2    (8),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait)
`ifdef DMEM_ACCESS_STATS_EN
    ,
    .read_count  (read_count),
    .write_count (write_count)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    string         name;
  } exp_t;

  exp_t          q[$];
  int            total    = 0;
  int            bad      = 0;
  int            cyc      = 0;
  int            resp_cnt = 0;

  // Reference model: line contents by index, last returned line, op counts.
  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] model_rd  = '0;
  int            model_rc  = 0;
  int            model_wc  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Monitor: a request held while busywait is low is the response cycle.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && (read || write) && !busywait) begin
      resp_cnt++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got response at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        chk({e.name, "_data"}, readdata, e.data);
        chk({e.name, "_latency"}, DW'(cyc), DW'(e.cyc));
        $display("resp %s cyc=%0d readdata=%h", e.name, cyc, readdata);
      end
    end
  end

  // Issue one request at posedge+1; returns at posedge+1 of the edge ending RESP
  // with the request still driven, so the caller may chain or drop it.
  task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit scramble, input string nm);
    exp_t e;
    int   idx;
    int   start;
    bit   done;
    idx       = int'(a[7:0]);
    read      = rd;
    write     = wr;
    address   = a;
    writedata = d;
    e.name    = nm;
    e.cyc     = cyc + (wr ? WL : RL) + 1;
    if (wr) begin
      model_mem[idx] = d;
      model_wc++;
    end else begin
      model_rd = model_mem.exists(idx) ? model_mem[idx] : 'x;
      model_rc++;
    end
    e.data = model_rd;
    q.push_back(e);
    start = resp_cnt;
    @(negedge clock);
    chk({nm, "_busy_on_req"}, DW'(busywait), DW'(1));
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clock);
      #1;
      if (resp_cnt != start) begin
        done = 1'b1;
        break;
      end
      if (scramble) begin
        address   = AW'($urandom);
        writedata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no response expected one within 200 cycles", nm);
    end
  endtask

  task automatic idle(input int n);
    read  = 1'b0;
    write = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_stats(input string nm);
`ifdef DMEM_ACCESS_STATS_EN
    chk({nm, "_read_count"}, DW'(read_count), DW'(model_rc));
    chk({nm, "_write_count"}, DW'(write_count), DW'(model_wc));
`else
    if (nm.len() < 0) $display("%s", nm);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    model_rd = '0;
    model_rc = 0;
    model_wc = 0;
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("reset_readdata", readdata, '0);
    chk("reset_busywait", DW'(busywait), DW'(0));
    check_stats("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Write, then assert reset while the latency counter reads 2.
  task automatic reset_mid(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit hold, input string nm);
    read      = 1'b0;
    write     = 1'b1;
    address   = a;
    writedata = d;
    repeat (WL - 2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    if (!hold) write = 1'b0;
    model_rd = '0;
    model_rc = 0;
    model_wc = 0;
    @(negedge clock);
    chk({nm, "_readdata"}, readdata, '0);
    check_stats(nm);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    if (hold) issue(1'b0, 1'b1, a, d, 1'b0, {nm, "_restart"});
    idle(1);
  endtask

  initial begin
    logic [DW-1:0] line_a;
    logic [DW-1:0] line_b;
    logic [AW-1:0] ra;
    int            idx;
    bit            wr;
    bit            both;
    int            gap;

    line_a    = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    line_b    = 128'h11111111_11111111_22222222_22222222;
    reset     = 1'b1;
    read      = 1'b0;
    write     = 1'b0;
    address   = '0;
    writedata = '0;

    do_reset();
    idle(1);

    issue(1'b0, 1'b1, 28'h0000003, line_a, 1'b0, "preload3");
    idle(1);
    issue(1'b1, 1'b0, 28'h0000003, '0, 1'b0, "read3");
    chk("read3_word0", DW'(readdata[31:0]), DW'(32'hAAAAAAAA));
    chk("read3_word3", DW'(readdata[127:96]), DW'(32'hDDDDDDDD));
    idle(2);

    issue(1'b0, 1'b1, 28'h0000005, line_b, 1'b0, "wb5");
    issue(1'b1, 1'b0, 28'h0000005, '0, 1'b0, "refill5");
    idle(1);

    issue(1'b0, 1'b1, 28'h0000009, {4{32'h09090909}}, 1'b0, "preload9");
    issue(1'b0, 1'b1, 28'h0000007, {4{32'h77770000}}, 1'b0, "preload7");
    idle(1);

    issue(1'b0, 1'b1, 28'h000000A, {4{32'h0A0A5A5A}}, 1'b1, "scr_wr");
    idle(1);
    issue(1'b1, 1'b0, 28'h000000A, '0, 1'b1, "scr_rd");
    issue(1'b1, 1'b0, 28'h0000009, '0, 1'b0, "scr_other9");
    issue(1'b1, 1'b0, 28'h0000003, '0, 1'b0, "scr_other3");
    idle(1);

    issue(1'b1, 1'b1, 28'h0000007, {16{8'hA5}}, 1'b0, "rdwr7");
    idle(1);
    issue(1'b1, 1'b0, 28'h0000007, '0, 1'b0, "read7");
    idle(1);

    issue(1'b0, 1'b1, 28'h1234512, {4{32'hC0DE0012}}, 1'b0, "alias_wr");
    issue(1'b1, 1'b0, 28'h0000012, '0, 1'b0, "alias_rd");
    idle(1);
    check_stats("mid");

    reset_mid(28'h0000009, {4{32'hDEAD0009}}, 1'b0, "abort");
    issue(1'b1, 1'b0, 28'h0000009, '0, 1'b0, "after_abort9");
    idle(1);
    model_mem[9] = {4{32'h09090909}};
    reset_mid(28'h0000009, {4{32'hBEEF0009}}, 1'b1, "rst_hold");
    issue(1'b1, 1'b0, 28'h0000009, '0, 1'b0, "after_restart9");
    idle(1);

    for (int i = 0; i < 40; i++) begin
      idx    = int'($urandom_range(0, 15));
      ra     = AW'($urandom);
      ra[7:0] = 8'(idx);
      wr     = !model_mem.exists(idx) || ($urandom_range(0, 1) == 1);
      both   = wr && ($urandom_range(0, 7) == 0);
      issue(both || !wr, wr, ra, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 3) == 0, "rnd");
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(gap);
    end
    idle(3);

    chk("queue_drained", DW'(q.size()), DW'(0));
    check_stats("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
